// File: rtl/biquad_mac_seq.sv
// Purpose : direct-form-I biquad scheduler, one shared signed multiplier and accumulator.
// Latency : 7 cycles from the accept edge to y_valid_o; at most 1 sample per 8 cycles.
// Backpr. : x_ready_o is high only in IDLE; y_o is held in OUT until y_ready_i.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   en_i                  allows new samples to be accepted
//   clear_i               synchronous flush: drop in-flight sample, zero history and sat_o
//   a11_i..b12_i [31:0]   coefficient words; the top COEFWIDTH bits are Q1.(COEFWIDTH-1)
//   x_i/x_valid_i/x_ready_o   input sample handshake
//   y_o/y_valid_o/y_ready_i   output sample handshake
//   sat_o                 sticky saturation flag
//   sat_cnt_o [15:0]      saturating clamp counter, present only with BIQUAD_SAT_CNT_EN
//
// Optional feature macro: BIQUAD_SAT_CNT_EN (adds sat_cnt_o).
// COEFWIDTH must be below 32 so that some low coefficient bits are left unused.

module biquad_mac_seq #(
  parameter int DATAWIDTH = 12,
  parameter int COEFWIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [31:0]          a11_i,
  input  logic [31:0]          a12_i,
  input  logic [31:0]          b10_i,
  input  logic [31:0]          b11_i,
  input  logic [31:0]          b12_i,
  input  logic [DATAWIDTH-1:0] x_i,
  input  logic                 x_valid_i,
  output logic                 x_ready_o,
  output logic [DATAWIDTH-1:0] y_o,
  output logic                 y_valid_o,
  input  logic                 y_ready_i,
  output logic                 sat_o
`ifdef BIQUAD_SAT_CNT_EN
  ,
  output logic [15:0]          sat_cnt_o
`endif
);

  localparam int PW = DATAWIDTH + COEFWIDTH;     // product width
  localparam int AW = PW + 3;                    // accumulator: 5 products never overflow
  localparam int RW = AW - (COEFWIDTH - 1);      // width after the rounding shift

  localparam logic signed [AW-1:0] RND  = {{(AW-COEFWIDTH+1){1'b0}}, 1'b1, {(COEFWIDTH-2){1'b0}}};
  localparam logic signed [RW-1:0] YMAX = {{(RW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] YMIN = {{(RW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, SAT, OUT} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic [2:0] step;

  // Coefficient snapshot taken at accept, so register-file writes only hit the next sample.
  logic signed [COEFWIDTH-1:0] c_b10, c_b11, c_b12, c_a11, c_a12;
  logic signed [DATAWIDTH-1:0] x0, x1, x2, y1, y2;
  logic signed [AW-1:0]        acc;

  logic signed [COEFWIDTH-1:0] mul_c;
  logic signed [DATAWIDTH-1:0] mul_d;
  logic signed [PW-1:0]        mul_c_ext, mul_d_ext, prod;
  logic signed [AW-1:0]        prod_ext, acc_nxt, acc_rnd;
  logic signed [RW-1:0]        r;
  logic signed [DATAWIDTH-1:0] y_sat;
  logic                        clamp_hi, clamp_lo, clamp;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    x_ready_o = 1'b0;
    y_valid_o = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        x_ready_o = en_i & ~clear_i & ~rst_i;
        accept    = x_valid_i & x_ready_o;
        if (accept) state_nxt = MAC;
      end
      MAC: if (step == 3'd4) state_nxt = SAT;
      SAT: state_nxt = OUT;
      OUT: begin
        y_valid_o = 1'b1;
        if (y_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear_i) state_nxt = IDLE;
  end

  // ---------------- shared MAC datapath ----------------
  always_comb begin
    mul_c = c_b10;
    mul_d = x0;
    case (step)
      3'd1: begin mul_c = c_b11; mul_d = x1; end
      3'd2: begin mul_c = c_b12; mul_d = x2; end
      3'd3: begin mul_c = c_a11; mul_d = y1; end
      3'd4: begin mul_c = c_a12; mul_d = y2; end
      default: ;
    endcase
  end

  assign mul_c_ext = {{DATAWIDTH{mul_c[COEFWIDTH-1]}}, mul_c};
  assign mul_d_ext = {{COEFWIDTH{mul_d[DATAWIDTH-1]}}, mul_d};
  assign prod      = mul_c_ext * mul_d_ext;
  assign prod_ext  = {{3{prod[PW-1]}}, prod};
  // Feedback taps (steps 3 and 4) are subtracted.
  assign acc_nxt   = (step >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);

  // Round half up, drop the Q1.x fraction, then clamp to the sample range.
  assign acc_rnd  = acc + RND;
  assign r        = acc_rnd[AW-1:COEFWIDTH-1];
  assign clamp_hi = (r > YMAX);
  assign clamp_lo = (r < YMIN);
  assign clamp    = clamp_hi | clamp_lo;
  assign y_sat    = clamp_hi ? YMAX[DATAWIDTH-1:0] :
                    clamp_lo ? YMIN[DATAWIDTH-1:0] : r[DATAWIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step  <= '0;
      acc   <= '0;
      x0    <= '0;
      x1    <= '0;
      x2    <= '0;
      y1    <= '0;
      y2    <= '0;
      y_o   <= '0;
      sat_o <= 1'b0;
      c_b10 <= '0;
      c_b11 <= '0;
      c_b12 <= '0;
      c_a11 <= '0;
      c_a12 <= '0;
    end else if (clear_i) begin
      // y_o deliberately keeps its last value across a flush.
      step  <= '0;
      acc   <= '0;
      x0    <= '0;
      x1    <= '0;
      x2    <= '0;
      y1    <= '0;
      y2    <= '0;
      sat_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x0    <= x_i;
            c_b10 <= b10_i[31:32-COEFWIDTH];
            c_b11 <= b11_i[31:32-COEFWIDTH];
            c_b12 <= b12_i[31:32-COEFWIDTH];
            c_a11 <= a11_i[31:32-COEFWIDTH];
            c_a12 <= a12_i[31:32-COEFWIDTH];
            acc   <= '0;
            step  <= '0;
          end
        end
        MAC: begin
          acc  <= acc_nxt;
          step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
        end
        SAT: begin
          y_o <= y_sat;
          x2  <= x1;
          x1  <= x0;
          y2  <= y1;
          y1  <= y_sat;
          if (clamp) sat_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BIQUAD_SAT_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i)
      sat_cnt_o <= '0;
    else if (state == SAT && clamp && sat_cnt_o != 16'hFFFF)
      sat_cnt_o <= sat_cnt_o + 16'd1;
  end
`endif

  // Low coefficient bits and the rounded-away fraction are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{a11_i[31-COEFWIDTH:0], a12_i[31-COEFWIDTH:0], b10_i[31-COEFWIDTH:0],
                         b11_i[31-COEFWIDTH:0], b12_i[31-COEFWIDTH:0], acc_rnd[COEFWIDTH-2:0]};

endmodule

// File: tb/tb_biquad_mac_seq.sv
`timescale 1ns/1ps
module tb_biquad_mac_seq;
  localparam int DW = 12;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic [31:0] a11 = '0, a12 = '0, b10 = '0, b11 = '0, b12 = '0;
  logic [DW-1:0] x = '0;
  logic x_valid = 1'b0, x_ready;
  logic [DW-1:0] y;
  logic y_valid, y_ready = 1'b1, sat;
`ifdef BIQUAD_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  biquad_mac_seq #(.DATAWIDTH(DW), .COEFWIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr),
    .a11_i(a11), .a12_i(a12), .b10_i(b10), .b11_i(b11), .b12_i(b12),
    .x_i(x), .x_valid_i(x_valid), .x_ready_o(x_ready),
    .y_o(y), .y_valid_o(y_valid), .y_ready_i(y_ready), .sat_o(sat)
`ifdef BIQUAD_SAT_CNT_EN
    , .sat_cnt_o(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  int     cyc = 0;
  bit     chk_en = 1'b0;
  bit     in_flight = 1'b0;
  int     acc_cyc = 0;
  int     pend_y = 0;
  bit     pend_s = 1'b0;
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
  bit     msat = 1'b0;
  int     msat_cnt = 0;
  bit     exp_rdy, exp_yv;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint cf(input logic [31:0] w);
    return longint'($signed(w[31:16]));
  endfunction

  // y = b10*x + b11*x1 + b12*x2 - a11*y1 - a12*y2 in Q1.15, rounded and clamped to 12 bits.
  task automatic model_sample(input longint xv, output int yv, output bit s);
    longint acc, q;
    acc = cf(b10) * xv + cf(b11) * mx1 + cf(b12) * mx2 - cf(a11) * my1 - cf(a12) * my2;
    q = (acc + 64'sd16384) >>> 15;
    s = 1'b0;
    if (q > 2047) begin q = 2047; s = 1'b1; end
    else if (q < -2048) begin q = -2048; s = 1'b1; end
    yv  = int'(q);
    mx2 = mx1; mx1 = xv;
    my2 = my1; my1 = q;
  endtask

  task automatic model_flush();
    in_flight = 1'b0;
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    msat = 1'b0;
    msat_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_yv  = in_flight && (cyc - acc_cyc >= 7);
      exp_rdy = !rst && !clr && en && !in_flight;
      if (exp_yv && (cyc - acc_cyc == 7) && pend_s) begin
        msat = 1'b1;
        if (msat_cnt != 16'hFFFF) msat_cnt++;
      end
      check(y_valid == exp_yv, "y_valid", y_valid, exp_yv);
      if (exp_yv) check(int'($signed(y)) == pend_y, "y_value", int'($signed(y)), pend_y);
      check(sat == msat, "sat", sat, msat);
`ifdef BIQUAD_SAT_CNT_EN
      check(int'(sat_cnt) == msat_cnt, "sat_cnt", sat_cnt, msat_cnt);
`endif
      check(x_ready == exp_rdy, "x_ready", x_ready, exp_rdy);
      if (rst || clr) begin
        model_flush();
      end else begin
        if (exp_yv && y_ready) in_flight = 1'b0;
        if (exp_rdy && x_valid) begin
          model_sample(longint'($signed(x)), pend_y, pend_s);
          in_flight = 1'b1;
          acc_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_coef(input logic [15:0] cb10, cb11, cb12, ca11, ca12);
    b10 = {cb10, 16'($urandom)};
    b11 = {cb11, 16'($urandom)};
    b12 = {cb12, 16'($urandom)};
    a11 = {ca11, 16'($urandom)};
    a12 = {ca12, 16'($urandom)};
  endtask

  task automatic rand_coef();
    logic signed [15:0] c [5];
    for (int i = 0; i < 5; i++) begin
      c[i] = 16'($urandom);
      c[i] = c[i] >>> ($urandom % 3);
    end
    set_coef(c[0], c[1], c[2], c[3], c[4]);
  endtask

  task automatic send(input int xv);
    bit got;
    got = 1'b0;
    x = 12'(xv);
    x_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (x_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    x_valid = 1'b0;
    check(got, "accept_wait", got, 1);
  endtask

  task automatic get(output int yv, output int lat);
    bit got;
    got = 1'b0; yv = 0; lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (y_valid) begin got = 1'b1; yv = int'($signed(y)); end
    end
    @(posedge clk); #1;
    check(got, "output_wait", got, 1);
  endtask

  task automatic run(input int xv, input int expv, input string name);
    int yv, lat;
    send(xv);
    get(yv, lat);
    check(yv == expv, name, yv, expv);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int yv, lat;
    bit got;

    // Reset state.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check(x_ready == 1'b0, "rst_x_ready", x_ready, 0);
    check(y_valid == 1'b0, "rst_y_valid", y_valid, 0);
    check(y == '0, "rst_y", y, 0);
    check(sat == 1'b0, "rst_sat", sat, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    en  = 1'b1;

    // Gain 0.5.
    set_coef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    send(1024);
    get(yv, lat);
    check(yv == 512, "gain_y", yv, 512);
    check(lat == 7, "gain_latency", lat, 7);

    // One-sample delay tap.
    pulse_clear();
    set_coef(16'h0, 16'h4000, 16'h0, 16'h0, 16'h0);
    run(1000, 0, "delay_y0");
    run(0, 500, "delay_y1");
    run(0, 0, "delay_y2");

    // First-order feedback.
    pulse_clear();
    set_coef(16'h7FFF, 16'h0, 16'h0, 16'hC000, 16'h0);
    run(1000, 1000, "fb_y0");
    run(0, 500, "fb_y1");
    run(0, 250, "fb_y2");
    check(sat == 1'b0, "fb_sat", sat, 0);

    // Positive saturation.
    pulse_clear();
    set_coef(16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0);
    run(2047, 2047, "sat_y0");
    check(sat == 1'b0, "sat_after_first", sat, 0);
    run(2047, 2047, "sat_y1_clamped");
    check(sat == 1'b1, "sat_after_second", sat, 1);
`ifdef BIQUAD_SAT_CNT_EN
    check(sat_cnt == 16'd1, "sat_cnt_one", sat_cnt, 1);
`endif

    // Flush at MAC step 2.
    set_coef(16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0);
    send(1000);
    @(posedge clk);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check(y_valid == 1'b0, "flush_y_valid", y_valid, 0);
    check(sat == 1'b0, "flush_sat", sat, 0);
    check(x_ready == 1'b1, "flush_idle", x_ready, 1);
    @(posedge clk); #1;
    repeat (12) @(posedge clk);
    #1;
    set_coef(16'h0, 16'h4000, 16'h0, 16'h0, 16'h0);
    run(1000, 0, "flush_history");

    // -1.0 * most-negative clamps; then reset mid-MAC.
    set_coef(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0);
    run(-2048, 2047, "neg_full_scale");
    check(sat == 1'b1, "neg_full_sat", sat, 1);
    set_coef(16'h4000, 16'h4000, 16'h0, 16'h0, 16'h0);
    send(1000);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(y == '0, "rst_mid_y", y, 0);
    check(y_valid == 1'b0, "rst_mid_y_valid", y_valid, 0);
    check(sat == 1'b0, "rst_mid_sat", sat, 0);
    check(x_ready == 1'b1, "rst_mid_idle", x_ready, 1);
    @(posedge clk); #1;
    set_coef(16'h0, 16'h4000, 16'h0, 16'h0, 16'h0);
    run(1000, 0, "rst_history");

    // Coefficient snapshot: b10 changes during MAC.
    pulse_clear();
    set_coef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    send(1000);
    b10 = {16'h7FFF, 16'h0};
    get(yv, lat);
    check(yv == 500, "snapshot_y", yv, 500);

    // Backpressure in OUT with a pending input.
    set_coef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    y_ready = 1'b0;
    send(400);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (y_valid) got = 1'b1;
    end
    check(got, "bp_wait", got, 1);
    @(posedge clk); #1;
    x = 12'd5;
    x_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(y_valid == 1'b1, "bp_valid_hold", y_valid, 1);
      check(int'($signed(y)) == 200, "bp_y_hold", int'($signed(y)), 200);
      check(x_ready == 1'b0, "bp_x_ready", x_ready, 0);
    end
    @(posedge clk); #1;
    x_valid = 1'b0;
    y_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check(y_valid == 1'b0, "bp_release", y_valid, 0);
    @(posedge clk); #1;

    // en_i low blocks accepts but not an in-flight sample.
    send(100);
    en = 1'b0;
    get(yv, lat);
    check(yv == 50, "en_low_inflight", yv, 50);
    @(negedge clk);
    check(x_ready == 1'b0, "en_low_ready", x_ready, 0);
    @(posedge clk); #1;
    en = 1'b1;

    // Randomized traffic against the reference.
    pulse_clear();
    rand_coef();
    for (int c = 0; c < 4000; c++) begin
      x_valid = ($urandom % 3) != 0;
      x       = 12'($urandom);
      y_ready = ($urandom % 4) != 0;
      en      = ($urandom % 8) != 0;
      clr     = ($urandom % 250) == 0;
      rst     = ($urandom % 900) == 0;
      if ($urandom % 40 == 0) rand_coef();
      @(posedge clk); #1;
    end
    x_valid = 1'b0; clr = 1'b0; rst = 1'b0; y_ready = 1'b1; en = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/biquad_mac_seq.md
Name: biquad_mac_seq

Overview:
- Serial scheduler for one direct-form-I biquad section built around a single shared signed multiplier and accumulator.
- Per accepted input sample it sequences the five coefficient products, then rounds, saturates, presents the output and updates the x/y history.
- Sits between the sample source/sink and the coefficient register file, whose a11/a12/b10/b11/b12 outputs feed it directly.

Parameters:
- DATAWIDTH, 12, sample width; x/y are two's complement signed.
- COEFWIDTH, 16, coefficient width; coefficients are Q1.(COEFWIDTH-1); the MSBs of the 32-bit register-file words are used.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous and active-high on clk_i.
- en_i  in  1  enables acceptance of new samples.
- clear_i  in  1  synchronous flush: abort the current sample, zero history, clear sat_o.
- a11_i, a12_i, b10_i, b11_i, b12_i  in  32 each  coefficient words; bits [31:32-COEFWIDTH] are used.
- x_i  in  DATAWIDTH  input sample.
- x_valid_i  in  1  input sample valid.
- x_ready_o  out  1  input ready.
- y_o  out  DATAWIDTH  filtered output.
- y_valid_o  out  1  output valid.
- y_ready_i  in  1  output accepted.
- sat_o  out  1  sticky saturation flag.

Behaviour:
- Filter equation: y = b10*x + b11*x1 + b12*x2 - a11*y1 - a12*y2.
  - x1, x2 = previous two accepted inputs.
  - y1, y2 = previous two saturated outputs.
- Reset values: state IDLE; x_ready_o=0 in the reset cycle; y_o=0; y_valid_o=0; sat_o=0; x1=x2=y1=y2=0; accumulator=0; step counter=0.
- FSM states:
  - IDLE:
    - x_ready_o = en_i & ~clear_i.
    - On x_valid_i & x_ready_o: latch x_i and snapshot all five coefficients, clear the accumulator, go to MAC.
  - MAC: 5 cycles, step 0..4 using pairs (b10,x), (b11,x1), (b12,x2), (a11,y1), (a12,y2).
    - Steps 3 and 4 subtract the product.
    - After step 4, go to SAT.
  - SAT (1 cycle):
    - r = (acc + 2^(COEFWIDTH-2)) >>> (COEFWIDTH-1), arithmetic shift.
    - Clamp r to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1]; on clamp set sat_o.
    - Load y_o; shift history (x2<=x1, x1<=x, y2<=y1, y1<=y_sat).
    - Go to OUT.
  - OUT:
    - y_valid_o=1; y_o is held stable.
    - On y_ready_i: y_valid_o drops the next cycle and the FSM returns to IDLE.
- Latency: accept edge T; MAC edges T+1..T+5; SAT edge T+6; y_valid_o is high in the cycle after edge T+6 (7 cycles after accept).
  - Maximum throughput is 1 sample per 8 cycles with y_ready_i tied high.
- Arithmetic widths:
  - Product is DATAWIDTH+COEFWIDTH bits signed.
  - Accumulator is DATAWIDTH+COEFWIDTH+3 bits signed; no intermediate overflow for any inputs, including -1.0 * most-negative.
- Coefficients are snapshotted at accept; register-file writes during MAC/SAT/OUT affect only the next sample.
- x_ready_o is 0 in every state except IDLE; only one sample is in flight.
- clear_i in any state:
  - Next state IDLE; y_valid_o=0; history, accumulator and sat_o zeroed; y_o unchanged.
  - Any in-flight sample is discarded.
  - clear_i together with x_valid_i in IDLE: clear wins, the sample is not accepted.
- en_i low:
  - Blocks new accepts only.
  - An in-flight sample completes and is delivered.
- rst_i mid-operation: all outputs and state return to reset values on that edge; rst_i has priority over clear_i.

Optional Feature:
- Macro: BIQUAD_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt_o (out, 16 bits).
  - Increments by 1 on each SAT cycle that clamps; saturates at 0xFFFF.
  - Zeroed by rst_i or clear_i.
- Undefined: port and counter are absent; only sat_o reports saturation.

Test Plan (DATAWIDTH=12, COEFWIDTH=16, coefficients given as the upper 16 bits):
- Gain: b10=0x4000, others 0, x=1024 (0x400) → y_o=512 (0x200); y_valid_o rises exactly 7 cycles after the accept edge; x_ready_o low throughout.
- Delay tap: b11=0x4000, others 0, inputs 1000, 0, 0 → outputs 0, 500, 0.
- Feedback: b10=0x7FFF, a11=0xC000, others 0, inputs 1000, 0, 0 → outputs 1000, 500, 250; sat_o stays 0.
- Saturation: b10=b11=0x7FFF, inputs 2047, 2047 → outputs 2047, 2047 (second output clamped from 4094); sat_o=1 after the second SAT; with BIQUAD_SAT_CNT_EN, sat_cnt_o=1.
- Backpressure and coefficient snapshot:
  - Hold y_ready_i=0 for 10 cycles in OUT → y_o/y_valid_o stable, x_ready_o=0, a pending x_valid_i is not accepted.
  - Change b10 during MAC → current output uses the old b10.
- Flush and reset:
  - Pulse clear_i at MAC step 2 → next cycle IDLE, y_valid_o never rises, sat_o=0; next input 1000 with b11=0x4000 yields 0 (history cleared).
  - Repeat the same sequence with rst_i instead → same result, plus y_o=0.
